// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 main controller: sequences fetch/decode/execute over a shared ALU,
// memory port and register file, counts retired instructions and traps on illegal ones.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             alu_invalid,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             trap,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_comb begin
        // NOTE: default assignment first so every path drives state_d; no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = alu_invalid ? S_TRAP : S_ALUWB;
            S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // An instruction retires on the edge that takes its final state back to FETCH.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
            S_MEMWR: retire = mem_ready;
            default: retire = 1'b0;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    // Control outputs decode the registered state; only FETCH and BRANCH gate on live inputs.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_en     = zero;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: a per-cycle scoreboard of expected state,
// control outputs and retired count, plus a 4-bit-counter instance for wrap-around.
module tb_mips_multicycle_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                           S_JUMP = 4'd12, S_TRAP = 4'd15;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                           OP_BAD = 6'b111111;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } ctl_t;

    typedef struct packed {
        logic [3:0]  state;
        ctl_t        ctl;
        logic [31:0] retired;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0, mem_ready = 1'b0, alu_invalid = 1'b0;

    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, trap;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        pc_en_w, iord_w, mem_read_w, mem_write_w, ir_write_w, reg_dst_w, mem_to_reg_w, reg_write_w, alu_src_a_w, trap_w;
    logic [1:0]  alu_src_b_w, alu_op_w, pc_source_w;
    logic [3:0]  state_w;
    logic [3:0]  retired_w;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_invalid(alu_invalid), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .trap(trap), .state(state), .retired(retired)
    );

    mips_multicycle_ctrl #(.CNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_invalid(alu_invalid), .pc_en(pc_en_w), .iord(iord_w), .mem_read(mem_read_w),
        .mem_write(mem_write_w), .ir_write(ir_write_w), .reg_dst(reg_dst_w), .mem_to_reg(mem_to_reg_w),
        .reg_write(reg_write_w), .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w), .alu_op(alu_op_w),
        .pc_source(pc_source_w), .trap(trap_w), .state(state_w), .retired(retired_w)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    int         model_ret = 0;
    logic [5:0] cur_op = 6'd0;
    exp_t       sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, obs, exp, $time);
        else n_pass++;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected control word for a state, straight from the state/output table.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic mr, input logic z);
        ctl_t c;
        c = '0;
        case (st)
            S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_en = mr; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_en = z; end
            S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP:   begin c.pc_source = 2'b10; c.pc_en = 1'b1; end
            S_TRAP:   c.trap = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

    // Push the expectation for the current cycle, let outputs settle, then pop and compare.
    task automatic sample(input logic [3:0] st, input logic mr, input logic z);
        exp_t e;
        ctl_t o;
        e.state   = st;
        e.ctl     = exp_ctl(st, mr, z);
        e.retired = 32'(model_ret);
        sb.push_back(e);
        #1;
        o = '{pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
              reg_write, alu_src_a, alu_src_b, alu_op, pc_source, trap};
        e = sb.pop_front();
        check($sformatf("state(exp %0d)", e.state), 64'(state), 64'(e.state));
        check($sformatf("ctl(state %0d)", e.state), 64'(o), 64'(e.ctl));
        check($sformatf("retired(state %0d)", e.state), 64'(retired), 64'(e.retired));
    endtask

    task automatic cycle(input logic [3:0] st, input logic mr, input logic z, input logic inv);
        #1;
        opcode      = cur_op;
        mem_ready   = mr;
        zero        = z;
        alu_invalid = inv;
        sample(st, mr, z);
        @(posedge clk);
    endtask

    // Drives one instruction; inputs the state ignores are randomised.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z, input logic inv);
        cur_op = op;
        repeat (fw) cycle(S_FETCH, 1'b0, rb(), rb());
        cycle(S_FETCH, 1'b1, rb(), rb());
        cycle(S_DECODE, rb(), rb(), rb());
        case (op)
            OP_R: begin
                cycle(S_EXEC, rb(), rb(), inv);
                if (inv) return;
                cycle(S_ALUWB, rb(), rb(), rb());
            end
            OP_LW: begin
                cycle(S_MEMADR, rb(), rb(), rb());
                repeat (mw) cycle(S_MEMRD, 1'b0, rb(), rb());
                cycle(S_MEMRD, 1'b1, rb(), rb());
                cycle(S_MEMWB, rb(), rb(), rb());
            end
            OP_SW: begin
                cycle(S_MEMADR, rb(), rb(), rb());
                repeat (mw) cycle(S_MEMWR, 1'b0, rb(), rb());
                cycle(S_MEMWR, 1'b1, rb(), rb());
            end
            OP_BEQ:  cycle(S_BRANCH, rb(), z, rb());
            OP_ADDI: begin
                cycle(S_ADDIEX, rb(), rb(), rb());
                cycle(S_ADDIWB, rb(), rb(), rb());
            end
            OP_J:    cycle(S_JUMP, rb(), rb(), rb());
            default: return;
        endcase
        model_ret++;
    endtask

    task automatic trap_cycles(input int n);
        repeat (n) cycle(S_TRAP, rb(), rb(), rb());
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases it away from the edge.
    task automatic reset_dut();
        #1;
        reset     = 1'b1;
        model_ret = 0;
        sample(S_IDLE, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        sample(S_IDLE, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        reset_dut();

        run_instr(OP_R,    0, 0, 1'b0, 1'b0);
        run_instr(OP_LW,   0, 0, 1'b0, 1'b0);
        run_instr(OP_SW,   0, 0, 1'b0, 1'b0);
        run_instr(OP_BEQ,  0, 0, 1'b1, 1'b0);
        run_instr(OP_ADDI, 0, 0, 1'b0, 1'b0);
        run_instr(OP_J,    0, 0, 1'b0, 1'b0);
        #1;
        check("retired_after_stream", 64'(retired), 64'd6);

        run_instr(OP_LW,  3, 2, 1'b0, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b0, 1'b0);

        run_instr(OP_BAD, 0, 0, 1'b0, 1'b0);
        trap_cycles(20);
        reset_dut();

        run_instr(OP_ADDI, 1, 0, 1'b0, 1'b0);
        run_instr(OP_R,    0, 0, 1'b0, 1'b1);
        trap_cycles(3);
        reset_dut();

        run_instr(OP_J, 0, 0, 1'b0, 1'b0);
        cur_op = OP_SW;
        cycle(S_FETCH, 1'b1, rb(), rb());
        cycle(S_DECODE, rb(), rb(), rb());
        cycle(S_MEMADR, rb(), rb(), rb());
        #1;
        mem_ready = 1'b0;
        sample(S_MEMWR, 1'b0, zero);
        reset_dut();

        for (int i = 0; i < 17; i++)
            run_instr((i % 2 == 1) ? OP_J : OP_ADDI, i % 2, 0, rb(), 1'b0);
        #1;
        check("retired_17_instr", 64'(retired), 64'd17);
        check("retired_wrap_cnt4", 64'(retired_w), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
